// File: rtl/pipe_stage_reg_pkg.sv
//------------------------------------------------------------------------------
// Module  : pipe_pkg
// Brief   : Shared state encoding and bubble-value helpers for pipeline stage regs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [31:0]  MIPS_NOP    = 32'h0000_0000;
  localparam int unsigned  c_nop_max_w = 1024;

  // Wide vector of back-to-back NOP words; callers size-cast it to their payload width.
  function automatic logic [c_nop_max_w-1:0] nop_fill();
    return {(c_nop_max_w/32){MIPS_NOP}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module  : pipe_stage_reg
// Brief   : Valid/ready pipeline register with one-entry skid buffer, flush and
//           saturating stall counter; invalid outputs present a bubble value.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W    = 64,
  parameter logic [DATA_W-1:0]   NOP_VALUE = DATA_W'(nop_fill()),
  parameter int unsigned         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] c_stall_max = '1;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      // Stall accounting survives flush; only reset clears it.
      if (r_out_valid && !out_ready && (r_stall_cnt != c_stall_max))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (flush) begin
        r_state     <= EMPTY;
        r_main      <= NOP_VALUE;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_in_xfer) begin
              r_state     <= FULL;
              r_main      <= in_data;
              r_out_valid <= 1'b1;
            end
          end
          FULL: begin
            if (w_in_xfer && w_out_xfer) begin
              r_main <= in_data;
            end else if (w_out_xfer) begin
              r_state     <= EMPTY;
              r_main      <= NOP_VALUE;
              r_out_valid <= 1'b0;
            end else if (w_in_xfer) begin
              // Downstream stalled while upstream still sent: park the newcomer.
              r_state    <= SKID;
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
            end
          end
          SKID: begin
            if (w_out_xfer) begin
              r_state    <= FULL;
              r_main     <= r_skid;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state     <= EMPTY;
            r_main      <= NOP_VALUE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module  : tb_pipe_stage_reg
// Brief   : Directed and randomised checks of pipe_stage_reg with a queue model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W = 32;
  localparam int unsigned       CNT_W  = 4;
  localparam logic [DATA_W-1:0] NOP    = 32'hFFFF_0000;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks;
  int n_err;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .NOP_VALUE(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; one rising edge passes per tick.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  logic [31:0] q[$];
  logic [31:0] next_val;
  logic        hold;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, NOP);
    check("rst_stall", {28'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming 1..8 with a ready sink: one-cycle latency, no bubbles.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k, 1'b1);
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data", out_data, k);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_nop", out_data, NOP);
    check("stream_no_stall", {28'd0, stall_cnt}, 32'd0);

    // Backpressure: A lands in main, B in skid, C waits upstream.
    drive(1'b1, 32'hA, 1'b0); tick();
    check("bp_a", out_data, 32'hA);
    drive(1'b1, 32'hB, 1'b0); tick();
    check("bp_skid_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hC, 1'b0); tick();
    drive(1'b1, 32'hC, 1'b0); tick();
    check("bp_stall3", {28'd0, stall_cnt}, 32'd3);
    check("bp_hold_a", out_data, 32'hA);
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hC, 1'b1); tick();
    check("bp_b", out_data, 32'hB);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'hC, 1'b1); tick();
    check("bp_c", out_data, 32'hC);
    drive(1'b0, 32'h0, 1'b1); tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while in SKID with a competing input.
    drive(1'b1, 32'hE, 1'b0); tick();
    drive(1'b1, 32'hF, 1'b0); tick();
    check("fl_skid", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'hD, 1'b0); tick();
    flush = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_nop", out_data, NOP);
    check("fl_ready", {31'd0, in_ready}, 32'd1);
    check("fl_keeps_stall", {28'd0, stall_cnt}, 32'd5);
    drive(1'b0, 32'h0, 1'b1); tick();
    check("fl_no_d", {31'd0, out_valid}, 32'd0);

    // Saturation of the 4-bit stall counter.
    drive(1'b1, 32'h55, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    check("sat_15", {28'd0, stall_cnt}, 32'd15);
    check("sat_data", out_data, 32'h55);
    drive(1'b0, 32'h0, 1'b1); tick();
    check("sat_hold", {28'd0, stall_cnt}, 32'd15);

    // Single-cycle ready drop: output stays valid every cycle, order kept.
    drive(1'b1, 32'h11, 1'b1); tick();
    check("drop_11", out_data, 32'h11);
    drive(1'b1, 32'h12, 1'b0); tick();
    check("drop_hold11", out_data, 32'h11);
    drive(1'b1, 32'h13, 1'b1); tick();
    check("drop_12", out_data, 32'h12);
    drive(1'b1, 32'h13, 1'b1); tick();
    check("drop_13", out_data, 32'h13);

    // Async reset while holding a skid entry.
    drive(1'b1, 32'h21, 1'b0); tick();
    check("ar_skid", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_nop", out_data, NOP);
    check("ar_stall", {28'd0, stall_cnt}, 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_ready", {31'd0, in_ready}, 32'd1);
    check("ar_valid_after", {31'd0, out_valid}, 32'd0);

    // Random traffic against a queue model of the two-entry stage.
    next_val = 32'h1000;
    hold     = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("rnd_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() == 0) check("rnd_nop", out_data, NOP);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        check("rnd_data", out_data, q[0]);
        void'(q.pop_front());
      end
      if (!hold) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = next_val;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        next_val = next_val + 32'd1;
        hold     = 1'b0;
      end else begin
        hold = in_valid;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
